// File: rtl/lsu_bridge_if.sv
// Data-memory bus between the load/store bridge (master) and the memory (slave).
// Synchronous req/gnt request phase, followed by an rvalid read-return phase.
interface lsu_bridge_if #(
  parameter int ADDR_W = 12
);
  logic              o_mem_req;
  logic              i_mem_gnt;
  logic              o_mem_we;
  logic [ADDR_W-3:0] o_mem_addr;
  logic [3:0]        o_mem_be;
  logic [31:0]       o_mem_wdata;
  logic              i_mem_rvalid;
  logic [31:0]       i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/lsu_bridge.sv
// Load/store unit between a single-cycle RV32I core and a req/gnt/rvalid data
// memory: aligns stores, extends loads, stalls the core until each access ends.
module lsu_bridge #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic              i_ld,
  input  logic              i_sw,
  input  logic [2:0]        i_funct3,
  output logic [31:0]       o_rdata,
  output logic              o_stall,
  output logic              o_fault,
  output logic              o_err,
  lsu_bridge_if.master      mem
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              access, bad;

  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = is_load;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // A simultaneous load and store strobe is treated as a load.
  always_comb begin
    access  = i_ld | i_sw;
    bad     = !f3_legal(i_ld, i_funct3) || misaligned(i_funct3, i_addr[1:0]);
    o_fault = access && (state_q == IDLE) && bad;
    o_stall = ((state_q == IDLE) && access && !bad) || (state_q == REQ) || (state_q == WAIT_R);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !bad) begin
          addr_d  = i_addr[ADDR_W-1:2];
          we_d    = !i_ld;
          be_d    = calc_be(i_funct3, i_addr[1:0]);
          wdata_d = lane_wdata(i_funct3, i_wdata);
          f3_d    = i_funct3;
          off_d   = i_addr[1:0];
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem.i_mem_gnt) begin
          state_d = we_q ? DONE : WAIT_R;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '0;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem.i_mem_rvalid) begin
          rdata_d = extract(f3_q, off_q, mem.i_mem_rdata);
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_rdata         = rdata_q;
  assign o_err           = err_q;
  assign mem.o_mem_req   = (state_q == REQ);
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_addr  = addr_q;
  assign mem.o_mem_be    = be_q;
  assign mem.o_mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_bridge.sv
// Randomized scoreboard bench for lsu_bridge: a core driver issues accesses and
// queues expectations, a memory responder answers, a monitor compares.
module tb_lsu_bridge;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [31:0]       i_wdata = '0;
  logic              i_ld = 1'b0;
  logic              i_sw = 1'b0;
  logic [2:0]        i_funct3 = '0;
  logic [31:0]       o_rdata;
  logic              o_stall, o_fault, o_err;

  lsu_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .i_addr(i_addr), .i_wdata(i_wdata), .i_ld(i_ld),
    .i_sw(i_sw), .i_funct3(i_funct3), .o_rdata(o_rdata), .o_stall(o_stall),
    .o_fault(o_fault), .o_err(o_err), .mem(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-3:0] addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } bus_t;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } res_t;

  bus_t        bus_q[$];
  res_t        res_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  int          cur_g = 0;
  int          cur_r = 1;
  logic [31:0] cur_rword = '0;
  logic [31:0] model_rdata = '0;

  // memory responder state
  bit          rd_pend = 1'b0;
  int          rd_wait = 0;
  int          req_cyc = 0;
  logic [31:0] rd_word = '0;

  // monitor state
  bit          prev_stall = 1'b0;
  int          run = 0;
  bus_t        mb;
  res_t        mr;

  // random stimulus
  int          r_kind, r_g, r_r;
  logic        r_ld, r_sw;
  logic [2:0]  r_f3;
  logic [ADDR_W-1:0] r_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Memory: grants after cur_g request cycles, returns read data cur_r cycles after gnt.
  initial begin
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = $urandom;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          bus.i_mem_rvalid = 1'b1;
          bus.i_mem_rdata  = rd_word;
          rd_pend          = 1'b0;
        end else begin
          rd_wait--;
        end
      end
      if (bus.o_mem_req) begin
        if (req_cyc == cur_g) begin
          bus.i_mem_gnt = 1'b1;
          if (!bus.o_mem_we) begin
            rd_pend = 1'b1;
            rd_wait = cur_r - 1;
            rd_word = cur_rword;
          end
        end
        req_cyc++;
      end else begin
        req_cyc = 0;
      end
    end
  end

  // Monitor: bus handshakes, fault cycles and completion (DONE) cycles.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en || !reset) begin
        prev_stall = 1'b0;
        run        = 0;
        continue;
      end
      if (bus.o_mem_req && bus.i_mem_gnt) begin
        if (bus_q.size() == 0) fail_evt("bus_unexpected_req");
        else begin
          mb = bus_q.pop_front();
          check("mem_addr", 32'(bus.o_mem_addr), 32'(mb.addr));
          check("mem_we", 32'(bus.o_mem_we), 32'(mb.we));
          check("mem_be", 32'(bus.o_mem_be), 32'(mb.be));
          if (mb.we) check("mem_wdata", bus.o_mem_wdata, mb.wdata);
        end
      end
      if (o_fault) begin
        if (res_q.size() == 0) fail_evt("fault_unexpected");
        else begin
          mr = res_q.pop_front();
          check("fault_expected", 32'(o_fault), 32'(mr.fault));
          check("fault_stall", 32'(o_stall), 32'd0);
          check("fault_req", 32'(bus.o_mem_req), 32'd0);
          check("fault_rdata", o_rdata, mr.rdata);
          check("fault_stall_run", 32'(run), 32'(mr.stalls));
        end
      end else if (prev_stall && !o_stall) begin
        if (res_q.size() == 0) fail_evt("done_unexpected");
        else begin
          mr = res_q.pop_front();
          if (mr.fault) fail_evt("missed_fault");
          check("done_rdata", o_rdata, mr.rdata);
          check("done_err", 32'(o_err), 32'(mr.err));
          check("stall_cycles", 32'(run), 32'(mr.stalls));
        end
      end else if (o_err) begin
        fail_evt("err_outside_done");
      end
      run        = o_stall ? run + 1 : 0;
      prev_stall = o_stall;
    end
  end

  // Core-side driver: computes the expected outcome from the ISA rules, then holds
  // the instruction until the bridge lets it retire.
  task automatic issue(input logic ld, input logic sw, input logic [2:0] f3,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                       input int g, input int r, input logic [31:0] rw);
    bus_t        b;
    res_t        e;
    bit          legal, fault, tmo;
    int          sz, off, n;
    logic [31:0] v;
    off = int'(addr[1:0]);
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = ld ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
               : (f3 inside {3'b000, 3'b001, 3'b010});
    fault = !legal || ((off % sz) != 0);
    tmo   = 1'b0;
    if (fault) begin
      e.fault = 1'b1; e.rdata = model_rdata; e.err = 1'b0; e.stalls = 0;
    end else begin
      b.addr  = addr[ADDR_W-1:2];
      b.we    = !ld;
      b.be    = 4'(((1 << sz) - 1) << off);
      b.wdata = (sz == 1) ? {24'b0, wd[7:0]} * 32'h01010101 :
                (sz == 2) ? {16'b0, wd[15:0]} * 32'h00010001 : wd;
      if (g < TIMEOUT) bus_q.push_back(b);
      tmo = ld ? (g + r >= TIMEOUT) : (g >= TIMEOUT);
      if (ld) begin
        v = rw >> (8 * off);
        if (sz == 1) begin
          v = v & 32'hFF;
          if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2) begin
          v = v & 32'hFFFF;
          if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
        end
        model_rdata = tmo ? 32'h0 : v;
      end
      e.fault  = 1'b0;
      e.rdata  = model_rdata;
      e.err    = tmo;
      e.stalls = tmo ? TIMEOUT + 1 : (ld ? g + r + 2 : g + 2);
    end
    res_q.push_back(e);
    cur_g = g; cur_r = r; cur_rword = rw;
    i_ld = ld; i_sw = sw; i_funct3 = f3; i_addr = addr; i_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_stall && n < 60);
    if (o_stall) begin
      fail_evt("stall_never_released");
      finish_run();
    end
    @(posedge clk);
    #1;
    i_ld = 1'b0; i_sw = 1'b0;
    if (tmo) repeat (20) @(posedge clk);
    #0;
  endtask

  task automatic idle_cycle();
    i_ld = 1'b0; i_sw = 1'b0;
    i_funct3 = 3'($urandom);
    i_addr   = ADDR_W'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic random_block(input int count);
    for (int k = 0; k < count; k++) begin
      r_kind = $urandom_range(0, 9);
      if (r_kind == 0) idle_cycle();
      else begin
        r_ld   = (r_kind <= 5);
        r_sw   = (r_kind >= 5);
        r_f3   = 3'($urandom);
        r_addr = ADDR_W'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
          if (r_f3[1:0] == 2'b10) r_addr[1:0] = 2'b00;
        end
        r_g = $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) r_g = $urandom_range(4, 12);
        r_r = $urandom_range(1, 3);
        if ($urandom_range(0, 7) == 0) r_r = $urandom_range(4, 12);
        issue(r_ld, r_sw, r_f3, r_addr, $urandom, r_g, r_r, $urandom);
      end
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("rst_req", 32'(bus.o_mem_req), 32'd0);
    check("rst_we", 32'(bus.o_mem_we), 32'd0);
    check("rst_be", 32'(bus.o_mem_be), 32'd0);
    check("rst_addr", 32'(bus.o_mem_addr), 32'd0);
    check("rst_wdata", bus.o_mem_wdata, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    issue(1'b0, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF, 0, 1, 32'h0);
    issue(1'b0, 1'b1, 3'b000, 12'h013, 32'h000000A5, 0, 1, 32'h0);
    issue(1'b1, 1'b0, 3'b000, 12'h001, 32'h0, 0, 1, 32'h00008000);
    issue(1'b1, 1'b0, 3'b100, 12'h001, 32'h0, 0, 1, 32'h00008000);
    issue(1'b1, 1'b0, 3'b101, 12'h002, 32'h0, 1, 2, 32'hBEEF0000);
    issue(1'b1, 1'b0, 3'b010, 12'h006, 32'h0, 0, 1, 32'h0);
    issue(1'b1, 1'b0, 3'b011, 12'h008, 32'h0, 0, 1, 32'h0);
    issue(1'b0, 1'b1, 3'b100, 12'h008, 32'h12345678, 0, 1, 32'h0);
    issue(1'b0, 1'b1, 3'b001, 12'h00A, 32'h0000CAFE, 2, 1, 32'h0);
    issue(1'b1, 1'b0, 3'b001, 12'h00E, 32'h0, 0, 1, 32'h80001234);
    issue(1'b1, 1'b0, 3'b010, 12'h020, 32'h0, 1000, 1, 32'h0);
    issue(1'b1, 1'b0, 3'b010, 12'h024, 32'h0, 5, 10, 32'h0BADF00D);
    issue(1'b1, 1'b0, 3'b010, 12'h028, 32'h0, 5, 11, 32'h13579BDF);
    issue(1'b0, 1'b1, 3'b010, 12'h02C, 32'h11111111, 1000, 1, 32'h0);
    issue(1'b0, 1'b1, 3'b010, 12'h030, 32'h22222222, 15, 1, 32'h0);
    issue(1'b1, 1'b1, 3'b000, 12'h033, 32'hFFFFFFFF, 0, 1, 32'h7F000000);

    random_block(250);

    // Reset asserted during WAIT_R; the read data returns later and must be ignored.
    mon_en = 1'b0;
    cur_g = 0; cur_r = 3; cur_rword = 32'h12345678;
    i_ld = 1'b1; i_sw = 1'b0; i_funct3 = 3'b010; i_addr = 12'h040;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("wait_r_stall", 32'(o_stall), 32'd1);
    check("wait_r_req", 32'(bus.o_mem_req), 32'd0);
    reset = 1'b0;
    i_ld  = 1'b0;
    #1;
    check("rst_mid_req", 32'(bus.o_mem_req), 32'd0);
    check("rst_mid_stall", 32'(o_stall), 32'd0);
    check("rst_mid_rdata", o_rdata, 32'd0);
    check("rst_mid_be", 32'(bus.o_mem_be), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("late_rvalid_rdata", o_rdata, 32'd0);
      check("late_rvalid_stall", 32'(o_stall), 32'd0);
    end
    model_rdata = 32'h0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    random_block(150);

    repeat (3) @(posedge clk);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    finish_run();
  end
endmodule
